// File: rtl/scc_mem_arbiter.sv
// Single-port memory arbiter between SCC fetch and data ports.
// Data has priority; fetch wins after MAX_D_BURST back-to-back data grants.
module scc_mem_arbiter #(
    parameter int                 ADDR_W      = 32,
    parameter int                 DATA_W      = 32,
    parameter int                 RD_LATENCY  = 1,
    parameter logic [ADDR_W-1:0]  DATA_BASE   = 'h0000_1000,
    parameter int                 MAX_D_BURST = 4
) (
    input  logic              clk,
    input  logic              reset_s,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_valid,
    input  logic              d_rd,
    input  logic              d_wr,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_valid,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              core_stall
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_DONE
    } state_t;

    localparam logic [2:0] LAT_LAST  = 3'(RD_LATENCY - 1);
    localparam logic [3:0] BURST_MAX = 4'(MAX_D_BURST);

    state_t            state_q;
    state_t            state_d;
    logic              gnt_d_q;
    logic              is_wr_q;
    logic [2:0]        lat_cnt_q;
    logic [3:0]        d_streak_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_q;
    logic [DATA_W-1:0] if_rdata_q;
    logic [DATA_W-1:0] d_rdata_q;

    logic d_req;
    logic any_req;
    logic take_d;
    logic lat_last;
    logic grant;

    always_comb begin
        d_req    = d_rd | d_wr;
        any_req  = if_req | d_req;
        take_d   = d_req & ~(if_req & (d_streak_q == BURST_MAX));
        lat_last = (lat_cnt_q == LAT_LAST);
        grant    = (state_q == S_IDLE) & any_req;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (any_req) state_d = S_ISSUE;
            S_ISSUE: state_d = is_wr_q ? S_DONE : S_WAIT;
            S_WAIT:  if (lat_last) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset_s) begin
            state_q     <= S_IDLE;
            gnt_d_q     <= 1'b0;
            is_wr_q     <= 1'b0;
            lat_cnt_q   <= '0;
            d_streak_q  <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_rdata_q  <= '0;
            d_rdata_q   <= '0;
        end else begin
            state_q <= state_d;
            if (grant) begin
                gnt_d_q <= take_d;
                // d_rd together with d_wr resolves to a write
                is_wr_q <= take_d & d_wr;
                if (take_d) begin
                    mem_addr_q  <= d_addr + DATA_BASE;
                    mem_wdata_q <= d_wdata;
                end else begin
                    mem_addr_q <= if_addr;
                end
                if (take_d && if_req) begin
                    if (d_streak_q != BURST_MAX)
                        d_streak_q <= d_streak_q + 4'd1;
                end else begin
                    d_streak_q <= '0;
                end
            end
            if (state_q == S_ISSUE)
                lat_cnt_q <= '0;
            else if (state_q == S_WAIT)
                lat_cnt_q <= lat_cnt_q + 3'd1;
            if (state_q == S_WAIT && lat_last) begin
                if (gnt_d_q)
                    d_rdata_q <= mem_rdata;
                else
                    if_rdata_q <= mem_rdata;
            end
        end
    end

    always_comb begin
        mem_en     = ~reset_s & (state_q == S_ISSUE);
        mem_we     = mem_en & is_wr_q;
        mem_addr   = mem_addr_q;
        mem_wdata  = mem_wdata_q;
        if_rdata   = if_rdata_q;
        d_rdata    = d_rdata_q;
        if_valid   = ~reset_s & (state_q == S_DONE) & ~gnt_d_q;
        d_valid    = ~reset_s & (state_q == S_DONE) & gnt_d_q;
        core_stall = ~reset_s & ((state_q == S_ISSUE) |
                                 (state_q == S_WAIT) |
                                 ((state_q == S_IDLE) & any_req));
    end

endmodule
